// File: rtl/apb_pkg.sv
// apb_pkg: shared APB completer types and constants
package apb_pkg;
  localparam int APB_ADDR_W = 4;
  localparam int APB_DATA_W = 8;
  localparam logic [APB_ADDR_W-1:0] APB_STATUS_ADDR = 4'hF;
  typedef enum logic {APB_IDLE, APB_ACCESS} apb_state_t;
endpackage

// File: rtl/apb_wait_counter.sv
// apb_wait_counter: loadable down-counter with zero flag for APB wait states
module apb_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);
  assign zero = cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB3 completer, 16x8 register file with programmable wait states.
// Define APB_SLV_PSLVERR_EN to make 4'hF a read-only write-count status register with Pslverr.
module apb_slave_regfile import apb_pkg::*; #(
  parameter int              WAIT_CYCLES = 2,
  parameter logic [APB_DATA_W-1:0] RESET_VAL = 8'h00
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Psel,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [APB_ADDR_W-1:0] Paddr,
  input  logic [APB_DATA_W-1:0] Pwdata,
  output logic [APB_DATA_W-1:0] Prdata,
  output logic                  Pready,
  output logic                  Pslverr
);
  apb_state_t state, nxt;
  logic [APB_DATA_W-1:0] mem [16];
  logic [APB_DATA_W-1:0] rd_val;
  logic [3:0] cnt;
  logic setup, done, zero, wr;
  assign setup  = state == APB_IDLE && Psel && !Penable;
  assign Pready = state == APB_ACCESS && zero;
  assign done   = Psel && Penable && Pready;
  apb_wait_counter #(.W(4)) u_cnt (
    .clk(Clk), .rst_n(Reset), .load(setup),
    .dec(state == APB_ACCESS && Psel && Penable),
    .load_val(4'(WAIT_CYCLES)), .cnt(cnt), .zero(zero)
  );
  always_comb nxt = setup ? APB_ACCESS :
                    (state == APB_ACCESS && (!Psel || done)) ? APB_IDLE : state;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) state <= APB_IDLE;
    else state <= nxt;
`ifdef APB_SLV_PSLVERR_EN
  logic [APB_DATA_W-1:0] wcount;
  logic err;
  assign wr      = done && Pwrite && Paddr != APB_STATUS_ADDR;
  assign rd_val  = Paddr == APB_STATUS_ADDR ? wcount : mem[Paddr];
  assign Pslverr = Pready && err;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      wcount <= '0;
      err    <= 1'b0;
    end else begin
      if (wr) wcount <= wcount + 1'b1;
      if (setup) err <= Pwrite && Paddr == APB_STATUS_ADDR;
    end
`else
  assign wr      = done && Pwrite;
  assign rd_val  = mem[Paddr];
  assign Pslverr = 1'b0;
`endif
  // Prdata is captured at setup, so a write never disturbs its own transfer's read data
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) Prdata <= '0;
    else if (setup) Prdata <= rd_val;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) for (int i = 0; i < 16; i++) mem[i] <= RESET_VAL;
    else if (wr) mem[Paddr] <= Pwdata;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: directed checks of two completers (WAIT_CYCLES=2 and 0)
module tb_apb_slave_regfile;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic psel [2], pen [2], pwr [2], pready [2], pslverr [2];
  logic [3:0] paddr [2];
  logic [7:0] pwdata [2], prdata [2];
  int vectors = 0, miscompares = 0, cyc = 0, pa = 0, pb = 0;
  logic [7:0] m [16];
  logic [7:0] rd;
  logic err;
  int lat, pc, pc0, p0;
  logic [3:0] wa [10] = '{4'h0, 4'h5, 4'h9, 4'hC, 4'h1, 4'hE, 4'h6, 4'h5, 4'hB, 4'h8};
  logic [7:0] wd [10] = '{8'h13, 8'hC7, 8'h2E, 8'h90, 8'h4B, 8'hFE, 8'h01, 8'h6D, 8'hB2, 8'h80};
  logic [3:0] ra [10] = '{4'h5, 4'h0, 4'h9, 4'hD, 4'hC, 4'h1, 4'hE, 4'h6, 4'hB, 4'h8};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (pready[0]) pa++;
  always @(negedge clk) if (pready[1]) pb++;

  apb_slave_regfile #(.WAIT_CYCLES(2), .RESET_VAL(8'h3C)) u_a (
    .Clk(clk), .Reset(rst_n), .Psel(psel[0]), .Penable(pen[0]), .Pwrite(pwr[0]),
    .Paddr(paddr[0]), .Pwdata(pwdata[0]), .Prdata(prdata[0]), .Pready(pready[0]),
    .Pslverr(pslverr[0]));
  apb_slave_regfile #(.WAIT_CYCLES(0)) u_b (
    .Clk(clk), .Reset(rst_n), .Psel(psel[1]), .Penable(pen[1]), .Pwrite(pwr[1]),
    .Paddr(paddr[1]), .Pwdata(pwdata[1]), .Prdata(prdata[1]), .Pready(pready[1]),
    .Pslverr(pslverr[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input int u, input logic w, input logic [3:0] a, input logic [7:0] d,
                      output logic [7:0] r, output logic e, output int l, output int c);
    psel[u] = 1'b1; pen[u] = 1'b0; pwr[u] = w; paddr[u] = a; pwdata[u] = d;
    @(posedge clk); #1;
    pen[u] = 1'b1;
    l = 1;
    while (!pready[u] && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
    r = prdata[u]; e = pslverr[u]; c = cyc;
    @(posedge clk); #1;
    chk("rdy_one_cycle", pready[u], 0);
    psel[u] = 1'b0; pen[u] = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      psel[u] = 0; pen[u] = 0; pwr[u] = 0; paddr[u] = 0; pwdata[u] = 0;
    end
    for (int i = 0; i < 16; i++) m[i] = 8'h3C;
    tick(2);
    chk("rst_pready", pready[0], 0);
    chk("rst_prdata", prdata[0], 0);
    chk("rst_pslverr", pslverr[0], 0);
    rst_n = 1'b1;
    tick(2);
    // wait-state 0 completer, back-to-back
    xfer(1, 1, 4'h0, 8'h11, rd, err, lat, pc0);
    chk("w0_lat", lat, 1);
    xfer(1, 1, 4'h1, 8'h22, rd, err, lat, pc);
    chk("w0_lat2", lat, 1);
    chk("w0_b2b_gap", pc - pc0, 2);
    xfer(1, 0, 4'h0, 8'h00, rd, err, lat, pc);
    chk("w0_rd0", rd, 8'h11);
    xfer(1, 0, 4'h1, 8'h00, rd, err, lat, pc);
    chk("w0_rd1", rd, 8'h22);
    chk("w0_pulses", pb, 4);
    // penable without setup is ignored
    pen[0] = 1'b1; psel[0] = 1'b1;
    tick(4);
    chk("pen_no_setup", pa, 0);
    psel[0] = 0; pen[0] = 0;
    tick(1);
    // WAIT_CYCLES=2 write then read
    xfer(0, 1, 4'h3, 8'hA5, rd, err, lat, pc);
    chk("w2_wr_lat", lat, 3);
    chk("w2_wr_err", err, 0);
    xfer(0, 0, 4'h3, 8'h00, rd, err, lat, pc);
    chk("w2_rd_lat", lat, 3);
    chk("w2_rd3", rd, 8'hA5);
    xfer(0, 1, 4'h3, 8'h5C, rd, err, lat, pc);
    chk("w2_prewrite_rd", rd, 8'hA5);
    xfer(0, 0, 4'h3, 8'h00, rd, err, lat, pc);
    chk("w2_rd3_new", rd, 8'h5C);
    // reset while Pready is high on a write
    p0 = pa;
    psel[0] = 1; pen[0] = 0; pwr[0] = 1; paddr[0] = 4'h7; pwdata[0] = 8'hFF;
    tick(1);
    pen[0] = 1;
    tick(2);
    chk("mid_rdy_before", pready[0], 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pready", pready[0], 0);
    chk("mid_rst_prdata", prdata[0], 0);
    psel[0] = 0; pen[0] = 0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    xfer(0, 0, 4'h7, 8'h00, rd, err, lat, pc);
    chk("mid_rst_rd7", rd, 8'h3C);
    xfer(0, 0, 4'h3, 8'h00, rd, err, lat, pc);
    chk("rst_clears_3", rd, 8'h3C);
    // Psel dropped during access
    p0 = pa;
    psel[0] = 1; pen[0] = 0; pwr[0] = 1; paddr[0] = 4'h2; pwdata[0] = 8'h5A;
    tick(1);
    pen[0] = 1;
    tick(1);
    psel[0] = 0; pen[0] = 0;
    tick(5);
    chk("drop_no_pulse", pa - p0, 0);
    xfer(0, 0, 4'h2, 8'h00, rd, err, lat, pc);
    chk("drop_rd2", rd, 8'h3C);
    // ten writes then ten reads against a reference array
    p0 = pa;
    for (int i = 0; i < 10; i++) begin
      xfer(0, 1, wa[i], wd[i], rd, err, lat, pc);
      m[wa[i]] = wd[i];
      chk("rnd_wr_lat", lat, 3);
    end
    for (int i = 0; i < 10; i++) begin
      xfer(0, 0, ra[i], 8'h00, rd, err, lat, pc);
      chk($sformatf("rnd_rd_%0h", ra[i]), rd, m[ra[i]]);
    end
    chk("rnd_pulses", pa - p0, 20);
`ifdef APB_SLV_PSLVERR_EN
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      xfer(0, 1, 4'(i + 4), 8'h40, rd, err, lat, pc);
      chk("err_normal_wr", err, 0);
    end
    xfer(0, 1, 4'hF, 8'h99, rd, err, lat, pc);
    chk("err_status_wr", err, 1);
    chk("err_after", pslverr[0], 0);
    xfer(0, 0, 4'hF, 8'h00, rd, err, lat, pc);
    chk("status_count", rd, 8'h03);
    chk("status_rd_err", err, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
